// File: rtl/div_pkg.sv
// Shared widths and FSM encoding for the dividend-reconstruction multiplier.
package div_pkg;
  localparam int QW = 8;
  localparam int BW = 4;
  localparam int AW = QW + BW;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_reconstruct.sv
// Sequential shift-add unit computing a = q*b + r over BW cycles.
// Optional MUL_CHECK_EN flags operand tuples that no divider could have produced.
module div_reconstruct
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] q,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] r,
  output logic          busy,
  output logic          ready_out,
  output logic [AW-1:0] a,
  output logic          err
);

  localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] mq_q, mq_d;
  logic [BW-1:0] mb_q, mb_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a_q, a_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] acc_step;

  // Accumulator is seeded with r, so b = 0 naturally yields a = r.
  assign acc_step = mb_q[0] ? (acc_q + mq_q) : acc_q;

`ifdef MUL_CHECK_EN
  logic err_q, err_d;
  logic err_pend_q, err_pend_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mq_d    = mq_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    busy_d  = busy_q;
    ready_d = ready_q;
`ifdef MUL_CHECK_EN
    err_d      = err_q;
    err_pend_d = err_pend_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mq_d    = {{BW{1'b0}}, q};
          mb_d    = b;
          acc_d   = {{QW{1'b0}}, r};
          cnt_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = RUN;
`ifdef MUL_CHECK_EN
          err_d      = 1'b0;
          err_pend_d = (b == '0) || (r >= b);
`endif
        end
      end
      RUN: begin
        acc_d = acc_step;
        mq_d  = mq_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          a_d     = acc_step;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
`ifdef MUL_CHECK_EN
          err_d = err_pend_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mq_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef MUL_CHECK_EN
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mq_q    <= mq_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef MUL_CHECK_EN
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign ready_out = ready_q;
  assign a         = a_q;

endmodule

// File: tb/tb_div_reconstruct.sv
// Directed bench for div_reconstruct: latency, holding, ignored start, async reset, back-to-back.
module tb_div_reconstruct;
  import div_pkg::*;

  logic          clk;
  logic          rst;
  logic          start;
  logic [QW-1:0] q;
  logic [BW-1:0] b;
  logic [BW-1:0] r;
  logic          busy;
  logic          ready_out;
  logic [AW-1:0] a;
  logic          err;

  int nvec = 0;
  int nerr = 0;

  div_reconstruct dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .q         (q),
    .b         (b),
    .r         (r),
    .busy      (busy),
    .ready_out (ready_out),
    .a         (a),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and check the full busy/ready timeline through completion.
  task automatic run_op(input string tag, input logic [QW-1:0] qv, input logic [BW-1:0] bv,
                        input logic [BW-1:0] rv, input logic [AW-1:0] exp_a, input logic exp_err);
    start = 1'b1; q = qv; b = bv; r = rv;
    step();
    $display("op %s: q=%0d b=%0d r=%0d expect a=%0d", tag, qv, bv, rv, exp_a);
    start = 1'b0; q = ~qv; b = ~bv; r = ~rv;
    chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
    chk({tag, ".ready_e0"}, 32'(ready_out), 32'd0);
    for (int i = 1; i < BW; i++) begin
      step();
      chk({tag, ".busy_run"}, 32'(busy), 32'd1);
      chk({tag, ".ready_run"}, 32'(ready_out), 32'd0);
    end
    step();
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    chk({tag, ".ready_done"}, 32'(ready_out), 32'd1);
    chk({tag, ".a"}, 32'(a), 32'(exp_a));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  logic exp_err_b0;

  initial begin
`ifdef MUL_CHECK_EN
    exp_err_b0 = 1'b1;
`else
    exp_err_b0 = 1'b0;
`endif
    rst = 1'b0; start = 1'b0; q = '0; b = '0; r = '0;
    step();
    step();
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.ready", 32'(ready_out), 32'd0);
    chk("reset.a", 32'(a), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    rst = 1'b1;
    step();
    chk("idle.busy", 32'(busy), 32'd0);

    run_op("basic", 8'd7, 4'd7, 4'd5, 12'd54, 1'b0);
    step();
    step();
    chk("hold.ready", 32'(ready_out), 32'd1);
    chk("hold.a", 32'(a), 32'd54);

    run_op("max", 8'd255, 4'd15, 4'd14, 12'd3839, 1'b0);
    run_op("b_zero", 8'd9, 4'd0, 4'd3, 12'd3, exp_err_b0);

    // Start pulse during RUN must not re-sample operands.
    start = 1'b1; q = 8'd7; b = 4'd7; r = 4'd5;
    step();
    $display("op ignore: q=7 b=7 r=5, second start q=1 b=1 r=0 mid-run");
    start = 1'b0;
    step();
    start = 1'b1; q = 8'd1; b = 4'd1; r = 4'd0;
    step();
    start = 1'b0;
    chk("ignore.busy", 32'(busy), 32'd1);
    step();
    step();
    chk("ignore.ready", 32'(ready_out), 32'd1);
    chk("ignore.a", 32'(a), 32'd54);

    // Asynchronous reset mid-RUN.
    start = 1'b1; q = 8'd200; b = 4'd9; r = 4'd4;
    step();
    $display("op reset_mid: q=200 b=9 r=4 then rst after 2 run cycles");
    start = 1'b0;
    step();
    step();
    chk("rstmid.busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.ready", 32'(ready_out), 32'd0);
    chk("rstmid.a", 32'(a), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("rstmid.idle_busy", 32'(busy), 32'd0);
    chk("rstmid.idle_a", 32'(a), 32'd0);
    run_op("after_rst", 8'd6, 4'd3, 4'd2, 12'd20, 1'b0);

    // Back-to-back: second start accepted in the DONE cycle.
    run_op("b2b_1", 8'd3, 4'd5, 4'd2, 12'd17, 1'b0);
    run_op("b2b_2", 8'd10, 4'd4, 4'd1, 12'd41, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/div_reconstruct.md
# div_reconstruct

Sequential shift-add multiplier that rebuilds a dividend from a divider result: computes a = q*b + r from an 8-bit quotient, 4-bit divisor and 4-bit remainder. It is the inverse datapath of the sequential divider. It is used as a self-check partner: divider output feeds this block, and the result is compared against the original dividend. It also serves as a standalone small multiply-add unit with a start/ready handshake.

## Interface
- QW, 8: quotient width in bits
- BW, 4: divisor and remainder width in bits; also the number of iterations
- AW, QW+BW: result width (fixed derived value, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  request pulse; operands sampled on the same edge
- q  in  QW  quotient operand
- b  in  BW  divisor operand
- r  in  BW  remainder operand
- busy  out  1  high while iterating
- ready_out  out  1  result valid; held until next accepted start
- a  out  AW  reconstructed dividend q*b + r
- err  out  1  operand-tuple invalid (only with MUL_CHECK_EN)

## Operation
- States:
  - IDLE: after reset.
  - RUN: BW iterations.
  - DONE: result held.
- IDLE/DONE, start=1 at an edge:
  - Latch q into shift register mq (AW bits, zero-extended) and b into mb.
  - Set acc = zero-extended r and cnt = 0.
  - Clear ready_out and go to RUN.
- RUN, each edge:
  - If mb[0], acc = acc + mq (AW-bit add, no carry-out needed).
  - Shift mq left by 1 and mb right by 1; cnt = cnt + 1.
  - On the edge where cnt reaches BW-1, the step completes, then a = acc_next, ready_out = 1, and the state goes to DONE.
- start while in RUN is ignored; operands are not re-sampled.
- Inputs q, b and r may change freely after the accepting edge.
- DONE: a and ready_out hold until the next start. start in DONE restarts the operation, and ready_out falls on that edge.
- b = 0: the block still runs BW cycles and the result is a = r.
- Maximum result: 255*15 + 14 = 3839 < 2^12, so the result never overflows AW.
- Reset (rst=0, any time, including mid-RUN):
  - State IDLE.
  - busy, ready_out, err = 0.
  - a, acc, mq, mb, cnt = 0.
  - Effect is immediate and asynchronous.

## Timing
- Latency: start accepted at edge E0; ready_out = 1 and a valid after edge E0+BW (4 cycles with defaults).
- busy = 1 from after E0 until after E0+BW.
- busy and ready_out are never high together.
- Throughput: a new start is accepted in the cycle ready_out is high, giving one result per BW cycles back-to-back.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MUL_CHECK_EN defined:
  - At accept, register err_next = (b == 0) || (r >= b).
  - err updates together with ready_out (after E0+BW), holds in DONE, and clears on the next accepted start or on reset.
  - a is still computed normally.
- MUL_CHECK_EN undefined: the err port is present but tied to 0, and no comparator is built.

## Structure
- Shared package div_pkg holds:
  - Parameters QW, BW and AW.
  - State enum {IDLE, RUN, DONE}.
  - Iteration counter width $clog2(BW).
- Single module with no sub-module. The datapath is one adder plus two shift registers and does not justify a split.

## Test plan
- q=7, b=7, r=5, start pulse: busy for 4 cycles, then ready_out=1, a=54, err=0.
- q=255, b=15, r=14: a=3839 after 4 cycles; no overflow.
- q=9, b=0, r=3: a=3 after 4 cycles. err=1 with MUL_CHECK_EN; err=0 without it.
- Start with q=7, b=7, r=5, then pulse start with q=1, b=1, r=0 two cycles later: second start ignored, a=54.
- Start, then rst=0 for one cycle after 2 RUN cycles: immediately busy=0, ready_out=0, a=0, state IDLE. A new start afterward completes correctly.
- Back-to-back runs:
  - First run: q=3, b=5, r=2 gives a=17.
  - Start is held high in the DONE cycle with q=10, b=4, r=1.
  - ready_out drops for 4 cycles, then a=41.
